register_unit: RTL and testbench

- Single-entry storage register, one bit wide by default and parameterizable in width.
- A write enable gates the capture of write data on the rising clock edge.
- The stored value is driven continuously on the read port.
- Instantiated in arrays by generate loops in enclosing blocks, which select among the instances' read outputs.

---
 rtl/register_unit.sv | 67 ++++++
 tb/tb_register_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/register_unit.sv
// Single-entry storage register with per-bit write mask, synchronous clear and change pulse.
// Optional write-through read path when REGISTER_BYPASS_EN is defined.
module register_unit #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_en,
    input  logic [WIDTH-1:0] wd,
    input  logic [WIDTH-1:0] wmask,
    input  logic             clr,
    output logic [WIDTH-1:0] rd,
    output logic             updated
);

    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_nxt;

    function automatic logic [WIDTH-1:0] mask_merge(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] data,
        input logic [WIDTH-1:0] mask
    );
        return (cur & ~mask) | (data & mask);
    endfunction

    // Clear beats write; an unmasked or idle edge leaves r untouched.
    always_comb begin
        r_nxt = r;
        if (clr) begin
            r_nxt = RESET_VALUE;
        end else if (w_en) begin
            r_nxt = mask_merge(r, wd, wmask);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r       <= RESET_VALUE;
            updated <= 1'b0;
        end else begin
            r       <= r_nxt;
            updated <= (r_nxt != r);
        end
    end

`ifdef REGISTER_BYPASS_EN
    // Write-through: pending masked write is visible before the edge; reset still dominates.
    always_comb begin
        rd = r;
        if (rst) begin
            rd = RESET_VALUE;
        end else if (w_en && !clr) begin
            rd = mask_merge(r, wd, wmask);
        end
    end
`else
    assign rd = r;
`endif

`ifndef SYNTHESIS
    w_en_known_a : assert property (@(posedge clk) disable iff (rst) !$isunknown(w_en))
        else $error("register_unit: w_en is X/Z at clock edge");
`endif

endmodule

// File: tb/tb_register_unit.sv
// Bench for register_unit: 1-bit instance, 8-bit instance (RESET_VALUE 0xA5) and a 2-wide array.
module tb_register_unit;

    logic clk;
    logic rst;

    // 1-bit instance
    logic       w1_en, w1_wd, w1_mask, w1_clr, w1_rd, w1_upd;
    // 8-bit instance
    logic       w8_en, w8_clr, w8_rd_upd;
    logic [7:0] w8_wd, w8_mask, w8_rd;
    // array of two 1-bit instances
    logic       a_en;
    logic [1:0] a;
    logic [1:0] a_rd, a_upd;
    logic       a_sel;
    logic       a_mux;

    int n_cmp;
    int n_err;

    typedef struct packed {
        logic       clr;
        logic       w_en;
        logic [7:0] wd;
        logic [7:0] wmask;
        logic [7:0] rd;
        logic       upd;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] rd;
        logic       upd;
    } exp_t;

    localparam int NV = 11;
    vec_t vecs [NV];
    exp_t sb [$];

    register_unit #(.WIDTH(1), .RESET_VALUE(1'b0)) u1 (
        .clk(clk), .rst(rst), .w_en(w1_en), .wd(w1_wd), .wmask(w1_mask),
        .clr(w1_clr), .rd(w1_rd), .updated(w1_upd)
    );

    register_unit #(.WIDTH(8), .RESET_VALUE(8'hA5)) u8 (
        .clk(clk), .rst(rst), .w_en(w8_en), .wd(w8_wd), .wmask(w8_mask),
        .clr(w8_clr), .rd(w8_rd), .updated(w8_rd_upd)
    );

    for (genvar g = 0; g < 2; g++) begin : g_arr
        register_unit #(.WIDTH(1), .RESET_VALUE(1'b0)) u_a (
            .clk(clk), .rst(rst), .w_en(a_en), .wd(a[g]), .wmask(1'b1),
            .clr(1'b0), .rd(a_rd[g]), .updated(a_upd[g])
        );
    end

    assign a_mux = a_sel ? a_rd[1] : a_rd[0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty: got 0 entries, required 1");
        end else begin
            e = sb.pop_front();
            check($sformatf("vec%0d_rd", e.idx), 64'(w8_rd), 64'(e.rd));
            check($sformatf("vec%0d_upd", e.idx), 64'(w8_rd_upd), 64'(e.upd));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Masked-write / clear vectors for the 8-bit instance, starting from 0xA5.
        vecs[0]  = '{1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 8'hFF, 8'h0F, 8'h0F, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 8'hFF, 8'h0F, 8'h0F, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'h3C, 8'hFF, 8'h3C, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 8'hFF, 8'hFF, 8'hA5, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 8'h12, 8'hFF, 8'hA5, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h12, 8'h00, 8'hA5, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h5A, 8'hF0, 8'h55, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 8'h5A, 8'h0F, 8'h5A, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'h5A, 1'b0};

        rst = 1'b1;
        w1_en = 1'b0; w1_wd = 1'b0; w1_mask = 1'b1; w1_clr = 1'b0;
        w8_en = 1'b0; w8_wd = 8'h00; w8_mask = 8'hFF; w8_clr = 1'b0;
        a_en = 1'b0; a = 2'b00; a_sel = 1'b0;

        // Reset state while rst is held
        repeat (2) @(negedge clk);
        #1;
        check("rst_u1_rd", 64'(w1_rd), 64'h0);
        check("rst_u1_upd", 64'(w1_upd), 64'h0);
        check("rst_u8_rd", 64'(w8_rd), 64'hA5);
        check("rst_u8_upd", 64'(w8_rd_upd), 64'h0);
        #1 rst = 1'b0;

        // Basic write on the 1-bit instance
        @(negedge clk);
        w1_en = 1'b1; w1_wd = 1'b1; w1_mask = 1'b1;
        #1;
`ifdef REGISTER_BYPASS_EN
        check("bypass_u1_same_cycle", 64'(w1_rd), 64'h1);
`else
        check("nobypass_u1_old_value", 64'(w1_rd), 64'h0);
`endif
        @(posedge clk); #1;
        check("basic_e1_rd", 64'(w1_rd), 64'h1);
        check("basic_e1_upd", 64'(w1_upd), 64'h1);
        w1_en = 1'b0; w1_wd = 1'b0;
        @(posedge clk); #1;
        check("basic_e2_rd", 64'(w1_rd), 64'h1);
        check("basic_e2_upd", 64'(w1_upd), 64'h0);

        // Toggle down then up so r=1 and updated=1 when reset strikes
        w1_en = 1'b1; w1_wd = 1'b0;
        @(posedge clk); #1;
        check("toggle0_rd", 64'(w1_rd), 64'h0);
        w1_wd = 1'b1;
        @(posedge clk); #1;
        check("toggle1_rd", 64'(w1_rd), 64'h1);
        check("toggle1_upd", 64'(w1_upd), 64'h1);

        // Asynchronous reset mid-cycle
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_rd", 64'(w1_rd), 64'h0);
        check("async_rst_upd", 64'(w1_upd), 64'h0);
        // Deassert mid-cycle with a write pending: no write until the next edge
        #2 rst = 1'b0;
        #1;
`ifndef REGISTER_BYPASS_EN
        check("rst_release_no_write", 64'(w1_rd), 64'h0);
`endif
        @(posedge clk); #1;
        check("post_rst_first_write", 64'(w1_rd), 64'h1);
        check("post_rst_first_upd", 64'(w1_upd), 64'h1);
        w1_en = 1'b0;

        // Array of two instances selected by a mux
        @(negedge clk);
        a = 2'b01; a_en = 1'b1;
        @(posedge clk); #1;
        a_en = 1'b0; a = 2'b00;
        check("arr_inst0_rd", 64'(a_rd[0]), 64'h1);
        check("arr_inst1_rd", 64'(a_rd[1]), 64'h0);
        a_sel = 1'b1; #1;
        check("arr_mux_sel1", 64'(a_mux), 64'h0);
        a_sel = 1'b0; #1;
        check("arr_mux_sel0", 64'(a_mux), 64'h1);

        // Table-driven vectors through the scoreboard
        for (int i = 0; i < NV; i++) begin
            exp_t e;
            @(negedge clk);
            w8_clr  = vecs[i].clr;
            w8_en   = vecs[i].w_en;
            w8_wd   = vecs[i].wd;
            w8_mask = vecs[i].wmask;
            e.idx = i; e.rd = vecs[i].rd; e.upd = vecs[i].upd;
            sb.push_back(e);
            @(posedge clk); #1;
            pop_check();
        end

        // Write-through visibility on the 8-bit instance (r = 0x5A)
        @(negedge clk);
        w8_clr = 1'b0; w8_en = 1'b1; w8_wd = 8'h00; w8_mask = 8'hF0;
        #1;
`ifdef REGISTER_BYPASS_EN
        check("bypass_u8_masked", 64'(w8_rd), 64'h0A);
`else
        check("nobypass_u8_hold", 64'(w8_rd), 64'h5A);
`endif
        w8_clr = 1'b1;
        #1;
        check("clr_pending_rd_is_r", 64'(w8_rd), 64'h5A);
        w8_clr = 1'b0; w8_en = 1'b0;
        @(posedge clk); #1;
        check("idle_hold_rd", 64'(w8_rd), 64'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
